// File: rtl/fine_delay_ctrl_if.sv
// ---------------------------------------------------------------------------
// fine_delay_ctrl_if
//   Bundles the signals between the fine delay controller and its environment
//   (phase detector, fine delay line, coarse controller, DLL top).
//   master : the controller itself (drives Q, coarse_req/dir, locked)
//   slave  : the environment (drives en, pd_up/pd_dn, coarse_ack)
//   Signals:
//     en          loop enable
//     pd_up/pd_dn phase detector samples (up = increase delay)
//     Q           thermometer code to the fine line, ones fill from MSB
//     coarse_req  coarse step request, held until coarse_ack
//     coarse_dir  1 = add coarse delay, 0 = remove
//     coarse_ack  coarse controller done
//     locked      loop locked
// ---------------------------------------------------------------------------
interface fine_delay_ctrl_if #(
  parameter int N_FINE = 6
);
  logic              en;
  logic              pd_up;
  logic              pd_dn;
  logic [N_FINE-1:0] Q;
  logic              coarse_req;
  logic              coarse_dir;
  logic              coarse_ack;
  logic              locked;

  modport master (
    input  en, pd_up, pd_dn, coarse_ack,
    output Q, coarse_req, coarse_dir, locked
  );

  modport slave (
    output en, pd_up, pd_dn, coarse_ack,
    input  Q, coarse_req, coarse_dir, locked
  );
endinterface

// File: rtl/fine_delay_ctrl.sv
// ---------------------------------------------------------------------------
// fine_delay_ctrl
//   Closed-loop controller for the fine delay line of a DLL. Phase detector
//   samples are integrated over windows of AVG_LEN cycles; each window yields
//   UP / DN / HOLD and moves the fine level by one tap. When the fine range is
//   exhausted a coarse step is requested over a req/ack handshake and the fine
//   level wraps to the opposite end. Lock is declared after LOCK_CNT
//   consecutive direction reversals and dropped after UNLOCK_THR consecutive
//   same-direction decisions.
//   Ports:
//     clk_in  reference clock, all state on the rising edge
//     rst_n   asynchronous active-low reset
//     bus     fine_delay_ctrl_if.master (en, pd_up, pd_dn, Q, coarse_req,
//             coarse_dir, coarse_ack, locked)
// ---------------------------------------------------------------------------
module fine_delay_ctrl #(
  parameter int N_FINE     = 6,
  parameter int AVG_LEN    = 4,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_THR = 3
) (
  input  logic               clk_in,
  input  logic               rst_n,
  fine_delay_ctrl_if.master  bus
);

  localparam int ACC_W  = $clog2(AVG_LEN) + 2;
  localparam int CNT_W  = $clog2(AVG_LEN);
  localparam int LVL_W  = $clog2(N_FINE + 1);
  localparam int ALT_W  = $clog2(LOCK_CNT + 1);
  localparam int SAME_W = $clog2(UNLOCK_THR + 1);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_FINE);
  localparam logic [LVL_W-1:0] LVL_MID = LVL_W'(N_FINE / 2);

  typedef enum logic [1:0] {
    S_TRACK,
    S_LOCKED,
    S_WAIT_ACK
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_e;

  // Level n -> n ones packed against the MSB (3 -> 111000 for six taps).
  function automatic logic [N_FINE-1:0] therm(input logic [LVL_W-1:0] lvl);
    logic [N_FINE-1:0] t;
    for (int i = 0; i < N_FINE; i++) begin
      t[i] = (i >= N_FINE - int'(lvl));
    end
    return t;
  endfunction

  state_e                    state_q;
  logic [LVL_W-1:0]          level_q;
  logic [N_FINE-1:0]         q_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [ALT_W-1:0]          alt_q;
  logic [SAME_W-1:0]         same_q;
  dir_e                      last_q;
  logic                      req_q;
  logic                      dir_q;
  logic                      locked_q;

  logic signed [ACC_W-1:0]   sample;
  logic signed [ACC_W-1:0]   sum;
  logic                      take;
  logic                      win_close;
  dir_e                      dec;
  logic                      sat_up;
  logic                      sat_dn;
  logic [LVL_W-1:0]          level_nx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sample = '0;
    if (bus.pd_up && !bus.pd_dn) begin
      sample = {{(ACC_W-1){1'b0}}, 1'b1};
    end else if (bus.pd_dn && !bus.pd_up) begin
      sample = '1;  // -1
    end

    // Accumulator is wide enough for +/-AVG_LEN, so the sum never wraps.
    sum       = acc_q + sample;
    take      = bus.en && (state_q != S_WAIT_ACK);
    win_close = take && (cnt_q == CNT_W'(AVG_LEN - 1));

    dec = DIR_NONE;
    if (sum[ACC_W-1]) begin
      dec = DIR_DN;
    end else if (sum != '0) begin
      dec = DIR_UP;
    end

    sat_up   = (dec == DIR_UP) && (level_q == LVL_MAX);
    sat_dn   = (dec == DIR_DN) && (level_q == '0);
    level_nx = (dec == DIR_UP) ? level_q + 1'b1 : level_q - 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: every register here is reset; there is no memory array to leave uninitialised.
    if (!rst_n) begin
      state_q  <= S_TRACK;
      level_q  <= LVL_MID;
      q_q      <= therm(LVL_MID);
      acc_q    <= '0;
      cnt_q    <= '0;
      alt_q    <= '0;
      same_q   <= '0;
      last_q   <= DIR_NONE;
      req_q    <= 1'b0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge values.
      // Window integration; cleared when disabled, while waiting for ack,
      // and on the edge that closes a window.
      if (win_close || !take) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_q + 1'b1;
      end

      unique case (state_q)
        S_WAIT_ACK: begin
          if (bus.coarse_ack) begin
            // Coarse step done: the fine line restarts from the far end.
            req_q   <= 1'b0;
            level_q <= dir_q ? '0 : LVL_MAX;
            q_q     <= therm(dir_q ? '0 : LVL_MAX);
            state_q <= S_TRACK;
            alt_q   <= '0;
            same_q  <= '0;
            last_q  <= DIR_NONE;
          end
        end

        S_TRACK, S_LOCKED: begin
          if (win_close && dec != DIR_NONE) begin
            if (sat_up || sat_dn) begin
              req_q    <= 1'b1;
              dir_q    <= sat_up;
              locked_q <= 1'b0;
              state_q  <= S_WAIT_ACK;
            end else begin
              level_q <= level_nx;
              q_q     <= therm(level_nx);
              last_q  <= dec;
              if (state_q == S_TRACK) begin
                // A reversal only counts once a previous direction exists.
                if (last_q != DIR_NONE && dec != last_q) begin
                  if (alt_q == ALT_W'(LOCK_CNT - 1)) begin
                    state_q  <= S_LOCKED;
                    locked_q <= 1'b1;
                    alt_q    <= '0;
                    same_q   <= '0;
                  end else begin
                    alt_q <= alt_q + 1'b1;
                  end
                end else begin
                  alt_q <= '0;
                end
              end else begin
                if (dec == last_q) begin
                  if (same_q == SAME_W'(UNLOCK_THR - 1)) begin
                    state_q  <= S_TRACK;
                    locked_q <= 1'b0;
                    alt_q    <= '0;
                    same_q   <= '0;
                  end else begin
                    same_q <= same_q + 1'b1;
                  end
                end else begin
                  same_q <= '0;
                end
              end
            end
          end
        end

        default: state_q <= S_TRACK;
      endcase
    end
  end

  assign bus.Q          = q_q;
  assign bus.coarse_req = req_q;
  assign bus.coarse_dir = dir_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_fine_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fine_delay_ctrl
//   Directed scenarios plus a randomized run, all compared against a
//   window-level behavioural model of the controller kept in this file.
// ---------------------------------------------------------------------------
module tb_fine_delay_ctrl;

  localparam int N     = 6;
  localparam int AVG   = 4;
  localparam int LOCKC = 4;
  localparam int UNL   = 3;

  localparam int MODE_TRACK  = 0;
  localparam int MODE_LOCKED = 1;
  localparam int MODE_WAIT   = 2;

  logic clk_in = 1'b0;
  logic rst_n;

  always #5 clk_in = ~clk_in;

  fine_delay_ctrl_if #(.N_FINE(N)) bus ();

  fine_delay_ctrl #(
    .N_FINE    (N),
    .AVG_LEN   (AVG),
    .LOCK_CNT  (LOCKC),
    .UNLOCK_THR(UNL)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int m_level;
  int m_mode;
  int m_last;   // 0 none, +1 up, -1 dn
  int m_alt;
  int m_same;
  bit m_req;
  bit m_dir;
  bit m_locked;
  int m_win[$];

  function automatic logic [N-1:0] exp_q(input int lvl);
    int v;
    v = ((1 << lvl) - 1) << (N - lvl);
    return v[N-1:0];
  endfunction

  task automatic model_reset();
    m_level  = N / 2;
    m_mode   = MODE_TRACK;
    m_last   = 0;
    m_alt    = 0;
    m_same   = 0;
    m_req    = 0;
    m_dir    = 0;
    m_locked = 0;
    m_win.delete();
  endtask

  task automatic model_edge(input bit en, input bit up, input bit dn, input bit ack);
    int s;
    int sum;
    int d;
    if (m_mode == MODE_WAIT) begin
      m_win.delete();
      if (ack) begin
        m_req   = 0;
        m_level = m_dir ? 0 : N;
        m_mode  = MODE_TRACK;
        m_alt   = 0;
        m_same  = 0;
        m_last  = 0;
      end
      return;
    end
    if (!en) begin
      m_win.delete();
      return;
    end
    s = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
    m_win.push_back(s);
    if (m_win.size() < AVG) return;
    sum = 0;
    foreach (m_win[i]) sum += m_win[i];
    m_win.delete();
    d = (sum > 0) ? 1 : ((sum < 0) ? -1 : 0);
    if (d == 0) return;
    if ((d > 0 && m_level == N) || (d < 0 && m_level == 0)) begin
      m_req    = 1;
      m_dir    = (d > 0);
      m_locked = 0;
      m_mode   = MODE_WAIT;
      return;
    end
    m_level += d;
    if (m_mode == MODE_TRACK) begin
      if (m_last != 0 && d != m_last) begin
        m_alt++;
        if (m_alt == LOCKC) begin
          m_mode   = MODE_LOCKED;
          m_locked = 1;
          m_same   = 0;
        end
      end else begin
        m_alt = 0;
      end
    end else begin
      if (d == m_last) begin
        m_same++;
        if (m_same == UNL) begin
          m_mode   = MODE_TRACK;
          m_locked = 0;
          m_alt    = 0;
          m_same   = 0;
        end
      end else begin
        m_same = 0;
      end
    end
    m_last = d;
  endtask

  // One rising edge; the model consumes the same inputs the DUT sampled.
  task automatic cycle();
    @(posedge clk_in);
    model_edge(bus.en, bus.pd_up, bus.pd_dn, bus.coarse_ack);
    #1;
  endtask

  task automatic set_pd(input bit up, input bit dn);
    bus.pd_up = up;
    bus.pd_dn = dn;
  endtask

  task automatic apply_reset();
    bus.en         = 1'b0;
    bus.pd_up      = 1'b0;
    bus.pd_dn      = 1'b0;
    bus.coarse_ack = 1'b0;
    rst_n          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.Q !== 6'b111000) begin
      errors++; $display("FAIL reset_q: got %b exp %b", bus.Q, 6'b111000);
    end
    checks++;
    if ({bus.coarse_req, bus.coarse_dir, bus.locked} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got req/dir/lock %b exp 000",
                         {bus.coarse_req, bus.coarse_dir, bus.locked});
    end
    // Run up a little, then pull reset asynchronously mid-cycle.
    bus.en = 1'b1;
    set_pd(1, 0);
    repeat (6) cycle();
    checks++;
    if (bus.Q !== 6'b111100) begin
      errors++; $display("FAIL reset_prerun_q: got %b exp %b", bus.Q, 6'b111100);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.Q !== 6'b111000 || bus.coarse_req !== 1'b0 || bus.locked !== 1'b0) begin
      errors++; $display("FAIL reset_async: got q=%b req=%b lock=%b exp q=111000 req=0 lock=0",
                         bus.Q, bus.coarse_req, bus.locked);
    end
    @(negedge clk_in);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (bus.Q !== 6'b111000 || bus.Q !== exp_q(m_level)) begin
        errors++; $display("FAIL reset_en0_stable c%0d: got %b exp %b", i, bus.Q, 6'b111000);
      end
    end
    set_pd(0, 0);
  endtask

  task automatic test_up_saturate();
    logic [N-1:0] exp_at [int];
    exp_at[4]  = 6'b111100;
    exp_at[8]  = 6'b111110;
    exp_at[12] = 6'b111111;
    exp_at[16] = 6'b111111;
    exp_at[20] = 6'b000000;
    bus.en = 1'b1;
    set_pd(1, 0);
    for (int e = 1; e <= 20; e++) begin
      bus.coarse_ack = (e == 20);
      cycle();
      if (exp_at.exists(e)) begin
        checks++;
        if (bus.Q !== exp_at[e]) begin
          errors++; $display("FAIL up_sat_q edge%0d: got %b exp %b", e, bus.Q, exp_at[e]);
        end
      end
      checks++;
      if (bus.coarse_req !== m_req || bus.Q !== exp_q(m_level)) begin
        errors++; $display("FAIL up_sat_model edge%0d: got req=%b q=%b exp req=%b q=%b",
                           e, bus.coarse_req, bus.Q, m_req, exp_q(m_level));
      end
      if (e == 16) begin
        checks++;
        if (bus.coarse_req !== 1'b1 || bus.coarse_dir !== 1'b1) begin
          errors++; $display("FAIL up_sat_req: got req=%b dir=%b exp 1 1",
                             bus.coarse_req, bus.coarse_dir);
        end
      end
      if (e == 20) begin
        checks++;
        if (bus.coarse_req !== 1'b0) begin
          errors++; $display("FAIL up_sat_ack_req: got %b exp 0", bus.coarse_req);
        end
      end
    end
    bus.coarse_ack = 1'b0;
    bus.en         = 1'b0;
    set_pd(0, 0);
  endtask

  task automatic test_down_saturate();
    bus.en = 1'b1;
    set_pd(0, 1);
    repeat (4) cycle();
    checks++;
    if (bus.coarse_req !== 1'b1 || bus.coarse_dir !== 1'b0 || bus.Q !== 6'b000000) begin
      errors++; $display("FAIL dn_sat_req: got req=%b dir=%b q=%b exp 1 0 000000",
                         bus.coarse_req, bus.coarse_dir, bus.Q);
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (bus.coarse_req !== 1'b1 || bus.Q !== 6'b000000) begin
        errors++; $display("FAIL dn_sat_frozen c%0d: got req=%b q=%b exp 1 000000",
                           i, bus.coarse_req, bus.Q);
      end
    end
    bus.coarse_ack = 1'b1;
    cycle();
    bus.coarse_ack = 1'b0;
    checks++;
    if (bus.Q !== 6'b111111 || bus.coarse_req !== 1'b0) begin
      errors++; $display("FAIL dn_sat_ack: got q=%b req=%b exp 111111 0", bus.Q, bus.coarse_req);
    end
    // Accumulator must restart from zero: first step a full window later.
    repeat (3) cycle();
    checks++;
    if (bus.Q !== 6'b111111) begin
      errors++; $display("FAIL dn_sat_acc_held_pre: got %b exp 111111", bus.Q);
    end
    cycle();
    checks++;
    if (bus.Q !== 6'b111110 || bus.Q !== exp_q(m_level)) begin
      errors++; $display("FAIL dn_sat_acc_held_post: got %b exp 111110", bus.Q);
    end
    bus.en = 1'b0;
    set_pd(0, 0);
  endtask

  task automatic test_window_mix();
    int pos;
    logic [3:0] pats [6];
    logic [3:0] p;
    pats = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    apply_reset();
    bus.en = 1'b1;
    // 3 up + 1 dn in random order -> +1
    pos = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) begin
      set_pd(i != pos, i == pos);
      cycle();
    end
    checks++;
    if (bus.Q !== 6'b111100 || bus.Q !== exp_q(m_level)) begin
      errors++; $display("FAIL mix_3up1dn: got %b exp %b", bus.Q, 6'b111100);
    end
    // 2 up + 2 dn -> hold
    p = pats[$urandom_range(0, 5)];
    for (int i = 0; i < 4; i++) begin
      set_pd(p[i], !p[i]);
      cycle();
    end
    checks++;
    if (bus.Q !== 6'b111100) begin
      errors++; $display("FAIL mix_2up2dn: got %b exp %b", bus.Q, 6'b111100);
    end
    // both high every sample -> hold
    for (int i = 0; i < 4; i++) begin
      set_pd(1, 1);
      cycle();
    end
    checks++;
    if (bus.Q !== 6'b111100) begin
      errors++; $display("FAIL mix_both_high: got %b exp %b", bus.Q, 6'b111100);
    end
    // one up among zero-valued samples (idle or both high) -> +1
    pos = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) begin
      if (i == pos) set_pd(1, 0);
      else if ($urandom_range(0, 1) == 1) set_pd(1, 1);
      else set_pd(0, 0);
      cycle();
    end
    checks++;
    if (bus.Q !== 6'b111110 || bus.Q !== exp_q(m_level)) begin
      errors++; $display("FAIL mix_1up: got %b exp %b", bus.Q, 6'b111110);
    end
    bus.en = 1'b0;
    set_pd(0, 0);
  endtask

  task automatic test_lock();
    int dirs [8];
    bit exp_lock [8];
    int exp_lvl [8];
    dirs     = '{1, -1, 1, -1, 1, 1, 1, 1};
    exp_lock = '{0, 0, 0, 0, 1, 1, 1, 0};
    exp_lvl  = '{1, 0, 1, 0, 1, 2, 3, 4};
    apply_reset();
    // Saturate upward and ack so the level restarts at 0 with no last direction.
    bus.en = 1'b1;
    set_pd(1, 0);
    repeat (16) cycle();
    bus.coarse_ack = 1'b1;
    cycle();
    bus.coarse_ack = 1'b0;
    checks++;
    if (bus.Q !== 6'b000000 || bus.coarse_req !== 1'b0) begin
      errors++; $display("FAIL lock_setup: got q=%b req=%b exp 000000 0", bus.Q, bus.coarse_req);
    end
    for (int w = 0; w < 8; w++) begin
      set_pd(dirs[w] > 0, dirs[w] < 0);
      repeat (AVG) cycle();
      checks++;
      if (bus.locked !== exp_lock[w] || bus.locked !== m_locked) begin
        errors++; $display("FAIL lock_state w%0d: got %b exp %b", w, bus.locked, exp_lock[w]);
      end
      checks++;
      if (bus.Q !== exp_q(exp_lvl[w]) || bus.Q !== exp_q(m_level)) begin
        errors++; $display("FAIL lock_q w%0d: got %b exp %b", w, bus.Q, exp_q(exp_lvl[w]));
      end
    end
    bus.en = 1'b0;
    set_pd(0, 0);
  endtask

  task automatic test_stray_ack();
    apply_reset();
    bus.coarse_ack = 1'b1;
    cycle();
    bus.coarse_ack = 1'b0;
    checks++;
    if (bus.Q !== 6'b111000 || bus.coarse_req !== 1'b0) begin
      errors++; $display("FAIL stray_ack_idle: got q=%b req=%b exp 111000 0", bus.Q, bus.coarse_req);
    end
    bus.en = 1'b1;
    set_pd(1, 0);
    for (int i = 0; i < 16; i++) begin
      bus.coarse_ack = ($urandom_range(0, 2) == 0);
      cycle();
      checks++;
      if (bus.Q !== exp_q(m_level) || bus.coarse_req !== m_req) begin
        errors++; $display("FAIL stray_ack_run c%0d: got q=%b req=%b exp q=%b req=%b",
                           i, bus.Q, bus.coarse_req, exp_q(m_level), m_req);
      end
      if (i == 15) bus.coarse_ack = 1'b0;
    end
    checks++;
    if (bus.coarse_req !== 1'b1 || bus.coarse_dir !== 1'b1) begin
      errors++; $display("FAIL stray_ack_req: got req=%b dir=%b exp 1 1", bus.coarse_req, bus.coarse_dir);
    end
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.coarse_req !== 1'b0 || bus.Q !== 6'b111000 || bus.locked !== 1'b0) begin
      errors++; $display("FAIL reset_during_req: got req=%b q=%b lock=%b exp 0 111000 0",
                         bus.coarse_req, bus.Q, bus.locked);
    end
    @(negedge clk_in);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    set_pd(0, 0);
  endtask

  task automatic test_random();
    int bias;
    bit alt_mode;
    int errs_before;
    apply_reset();
    bias     = 5;
    alt_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) alt_mode = ($urandom_range(0, 2) == 0);
      if (alt_mode) begin
        bus.en = 1'b1;
        bias   = ((c / AVG) % 2 == 0) ? 10 : 0;
      end else begin
        bus.en = ($urandom_range(0, 19) != 0);
        if (c % 16 == 0) bias = $urandom_range(0, 10);
      end
      set_pd($urandom_range(0, 9) < bias, $urandom_range(0, 9) >= bias);
      if (m_req) bus.coarse_ack = ($urandom_range(0, 3) == 0);
      else       bus.coarse_ack = ($urandom_range(0, 19) == 0);
      cycle();
      errs_before = errors;
      checks++;
      if (bus.Q !== exp_q(m_level)) begin
        errors++; $display("FAIL rand_q c%0d: got %b exp %b", c, bus.Q, exp_q(m_level));
      end
      checks++;
      if (bus.coarse_req !== m_req) begin
        errors++; $display("FAIL rand_req c%0d: got %b exp %b", c, bus.coarse_req, m_req);
      end
      checks++;
      if (bus.coarse_dir !== m_dir) begin
        errors++; $display("FAIL rand_dir c%0d: got %b exp %b", c, bus.coarse_dir, m_dir);
      end
      checks++;
      if (bus.locked !== m_locked) begin
        errors++; $display("FAIL rand_locked c%0d: got %b exp %b", c, bus.locked, m_locked);
      end
      if (errors - errs_before > 0 && errors > 40) break;
    end
    bus.en         = 1'b0;
    bus.coarse_ack = 1'b0;
    set_pd(0, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.pd_up      = 1'b0;
    bus.pd_dn      = 1'b0;
    bus.coarse_ack = 1'b0;
    test_reset();
    test_up_saturate();
    test_down_saturate();
    test_window_mix();
    test_lock();
    test_stray_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
